// File: rtl/vproc_pkg.sv
// vproc_pkg: shared types and constants for the virtual processor bus master,
// plus the host-software boundary (VInit / VSched).
//
// The bridge to the host program is the pair of routines VInit and VSched.
// In a co-simulation build they are foreign-language imports with the same
// names and argument order:
//     VInit(node)
//     VSched(node, irq, datain, dataout, addr, rw, ticks)
// Here they are written in SystemVerilog with the same argument order, so the
// slice elaborates without a C library. The host program's behaviour is then
// a per-call script held in the sc_* arrays, and each call is logged.
package vproc_pkg;

    // rw bit positions returned by VSched
    localparam int VP_WRITE = 0;
    localparam int VP_READ  = 1;

    // A returned tick count of -1 requests a delta-cycle handshake
    localparam int DELTA_TICKS = -1;

    // Host-side script depth; calls beyond it park the processor
    localparam int SCRIPT_LEN = 32;

    // Tick count returned once the script is exhausted
    localparam int PARK_TICKS = 1000;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_SCHED = 1'b1
    } vproc_state_t;

    // Host program script: entry i answers the i-th VSched call
    logic        [1:0]  sc_rw    [SCRIPT_LEN];
    logic        [31:0] sc_addr  [SCRIPT_LEN];
    logic        [31:0] sc_data  [SCRIPT_LEN];
    logic signed [31:0] sc_ticks [SCRIPT_LEN];

    // Call log
    int unsigned        vinit_count;
    logic        [3:0]  vinit_node;
    int unsigned        vsched_count;
    logic        [31:0] log_datain [SCRIPT_LEN];
    logic        [2:0]  log_irq    [SCRIPT_LEN];
    logic        [3:0]  log_node   [SCRIPT_LEN];

    function automatic void VInit(input logic [3:0] node);
        vinit_count = vinit_count + 1;
        vinit_node  = node;
    endfunction

    function automatic void VSched(
        input  logic [3:0]         node,
        input  logic [2:0]         irq,
        input  logic [31:0]        datain,
        output logic [31:0]        dataout,
        output logic [31:0]        addr,
        output logic [1:0]         rw,
        output logic signed [31:0] ticks
    );
        int unsigned idx;
        idx = vsched_count;
        if (idx < SCRIPT_LEN) begin
            log_datain[idx] = datain;
            log_irq[idx]    = irq;
            log_node[idx]   = node;
            dataout         = sc_data[idx];
            addr            = sc_addr[idx];
            rw              = sc_rw[idx];
            ticks           = sc_ticks[idx];
        end else begin
            dataout = 32'h0;
            addr    = 32'h0;
            rw      = 2'b00;
            ticks   = PARK_TICKS;
        end
        vsched_count = vsched_count + 1;
    endfunction

endpackage

// File: rtl/vproc.sv
// vproc: virtual processor bus master. Each rising edge it either completes
// an outstanding bus access, counts down idle ticks, waits for the delta
// handshake, or asks the host program (VSched) for the next access.
//
// Ports:
//   clk              clock, rising edge active
//   rst_n            asynchronous active-low reset
//   addr      [31:0] access address
//   dataout   [31:0] write data
//   we               write request, held until wrack
//   wrack            write acknowledge
//   datain    [31:0] read data, sampled on the acking edge
//   rd               read request, held until rdack
//   rdack            read acknowledge
//   interrupt [2:0]  interrupt level handed to the host program
//   update           toggles whenever new outputs are published
//   update_response  must equal update before the next host call
//   node      [3:0]  node number passed to every host call
module vproc
    import vproc_pkg::*;
#(
    parameter int DISABLE_DELTA = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] addr,
    output logic [31:0] dataout,
    output logic        we,
    input  logic        wrack,
    input  logic [31:0] datain,
    output logic        rd,
    input  logic        rdack,
    input  logic [2:0]  interrupt,
    output logic        update,
    input  logic        update_response,
    input  logic [3:0]  node
);

    vproc_state_t       state_reg;
    logic [31:0]        addr_reg;
    logic [31:0]        dataout_reg;
    logic               we_reg;
    logic               rd_reg;
    logic               update_reg;
    logic signed [31:0] tick_cnt_reg;

    logic hold;
    logic completing;
    logic read_done;

    // An access stays on the bus until its own ack; an ack for a request
    // that is not raised has no effect.
    assign hold       = (we_reg && !wrack) || (rd_reg && !rdack);
    assign completing = (we_reg && wrack) || (rd_reg && rdack);
    assign read_done  = rd_reg && rdack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_INIT;
            addr_reg     <= 32'h0;
            dataout_reg  <= 32'h0;
            we_reg       <= 1'b0;
            rd_reg       <= 1'b0;
            update_reg   <= 1'b0;
            tick_cnt_reg <= 32'sd0;
        end else begin
            case (state_reg)
                ST_INIT: begin
                    VInit(node);
                    state_reg <= ST_SCHED;
                end
                ST_SCHED: begin
                    if (hold) begin
                        // outputs frozen until the ack arrives
                    end else if (tick_cnt_reg > 0) begin
                        // The completing edge only retires the access; the
                        // idle ticks are counted on the edges after it.
                        if (completing) begin
                            we_reg <= 1'b0;
                            rd_reg <= 1'b0;
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg - 32'sd1;
                        end
                    end else if (update_reg != update_response) begin
                        we_reg <= 1'b0;
                        rd_reg <= 1'b0;
                    end else begin : do_call
                        logic [31:0]        s_data;
                        logic [31:0]        s_addr;
                        logic [1:0]         s_rw;
                        logic signed [31:0] s_ticks;
                        logic               n_we;
                        logic               n_rd;
                        logic [31:0]        n_addr;
                        logic [31:0]        n_data;
                        logic               delta;

                        VSched(node, interrupt, read_done ? datain : 32'h0,
                               s_data, s_addr, s_rw, s_ticks);

                        // Write wins when both rw bits are set
                        n_we   = s_rw[VP_WRITE];
                        n_rd   = s_rw[VP_READ] && !s_rw[VP_WRITE];
                        n_addr = (n_we || n_rd) ? s_addr : addr_reg;
                        n_data = n_we ? s_data : dataout_reg;
                        delta  = (s_ticks == DELTA_TICKS) && (DISABLE_DELTA == 0);

                        addr_reg    <= n_addr;
                        dataout_reg <= n_data;
                        we_reg      <= n_we;
                        rd_reg      <= n_rd;

                        if (delta || n_we != we_reg || n_rd != rd_reg ||
                            n_addr != addr_reg || n_data != dataout_reg) begin
                            update_reg <= ~update_reg;
                        end

                        // Zero and the delta code both mean "no idle ticks"
                        tick_cnt_reg <= (s_ticks > 0) ? s_ticks : 32'sd0;
                    end
                end
                default: state_reg <= ST_INIT;
            endcase
        end
    end

    assign addr    = addr_reg;
    assign dataout = dataout_reg;
    assign we      = we_reg;
    assign rd      = rd_reg;
    assign update  = update_reg;

endmodule

// File: tb/tb_vproc.sv
module tb_vproc;
    import vproc_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] dataout;
    logic        we;
    logic        wrack;
    logic [31:0] datain;
    logic        rd;
    logic        rdack;
    logic [2:0]  interrupt;
    logic        update;
    logic        update_response;
    logic [3:0]  node;

    // second instance with delta handshake disabled
    logic        rst_n1;
    logic [31:0] addr1;
    logic [31:0] dataout1;
    logic        we1;
    logic        rd1;
    logic        update1;

    // bus responder: wrack follows we; update_response tied or delayed 2 cycles
    logic ur_mode;
    logic ur_d1 = 1'b0;
    logic ur_d2 = 1'b0;

    int n_checks;
    int n_fail;
    logic prev_update;

    assign wrack           = we;
    assign update_response = ur_mode ? ur_d2 : update;

    always @(posedge clk) begin
        ur_d1 <= update;
        ur_d2 <= ur_d1;
    end

    vproc #(.DISABLE_DELTA(0)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .dataout(dataout), .we(we),
        .wrack(wrack), .datain(datain), .rd(rd), .rdack(rdack),
        .interrupt(interrupt), .update(update),
        .update_response(update_response), .node(node)
    );

    vproc #(.DISABLE_DELTA(1)) dut1 (
        .clk(clk), .rst_n(rst_n1), .addr(addr1), .dataout(dataout1), .we(we1),
        .wrack(we1), .datain(32'h0), .rd(rd1), .rdack(1'b0),
        .interrupt(3'd0), .update(update1),
        .update_response(update1), .node(4'd9)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step();
        step();
        n_checks++;
        if ({addr, dataout, we, rd, update} !== 67'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got addr=%h data=%h we=%b rd=%b upd=%b, want all 0",
                     addr, dataout, we, rd, update);
        end
        n_checks++;
        if (vinit_count !== 0) begin
            n_fail++;
            $display("FAIL reset_no_vinit: got %0d, want 0", vinit_count);
        end
        rst_n = 1'b1;
        step(); // E1: VInit
        n_checks++;
        if (vinit_count !== 1 || vinit_node !== 4'd5) begin
            n_fail++;
            $display("FAIL init_vinit: got count=%0d node=%0d, want 1/5", vinit_count, vinit_node);
        end
        n_checks++;
        if (vsched_count !== 0) begin
            n_fail++;
            $display("FAIL init_no_vsched: got %0d, want 0", vsched_count);
        end
        $display("reset/init: vinit=%0d vsched=%0d", vinit_count, vsched_count);
    endtask

    task automatic test_write();
        step(); // E2: call 0 -> write
        n_checks++;
        if (we !== 1'b1 || rd !== 1'b0 || addr !== 32'h10 || dataout !== 32'hDEADBEEF || vsched_count !== 1) begin
            n_fail++;
            $display("FAIL write_issue: got we=%b rd=%b addr=%h data=%h calls=%0d, want 1/0/10/deadbeef/1",
                     we, rd, addr, dataout, vsched_count);
        end
        n_checks++;
        if (log_irq[0] !== 3'd5 || log_node[0] !== 4'd5) begin
            n_fail++;
            $display("FAIL call_args: got irq=%0d node=%0d, want 5/5", log_irq[0], log_node[0]);
        end
        step(); // E3: ack edge, call 1 -> read
        n_checks++;
        if (we !== 1'b0 || vsched_count !== 2) begin
            n_fail++;
            $display("FAIL write_one_cycle: got we=%b calls=%0d, want 0/2", we, vsched_count);
        end
        n_checks++;
        if (log_datain[1] !== 32'h0) begin
            n_fail++;
            $display("FAIL datain_zero_on_write: got %h, want 0", log_datain[1]);
        end
        $display("write: addr=%h data=%h calls=%0d", 32'h10, 32'hDEADBEEF, vsched_count);
    endtask

    task automatic test_read();
        n_checks++;
        if (rd !== 1'b1 || addr !== 32'h0) begin
            n_fail++;
            $display("FAIL read_issue: got rd=%b addr=%h, want 1/0", rd, addr);
        end
        datain = 32'h1234;
        for (int i = 0; i < 3; i++) begin
            step(); // E4..E6: no ack
            n_checks++;
            if (rd !== 1'b1 || vsched_count !== 2) begin
                n_fail++;
                $display("FAIL read_hold[%0d]: got rd=%b calls=%0d, want 1/2", i, rd, vsched_count);
            end
        end
        rdack = 1'b1;
        step(); // E7: ack, call 2
        rdack = 1'b0;
        datain = 32'hFFFF_FFFF;
        n_checks++;
        if (rd !== 1'b0 || vsched_count !== 3 || log_datain[2] !== 32'h1234) begin
            n_fail++;
            $display("FAIL read_complete: got rd=%b calls=%0d datain=%h, want 0/3/1234",
                     rd, vsched_count, log_datain[2]);
        end
        $display("read: addr=%h datain=%h calls=%0d", 32'h0, log_datain[2], vsched_count);
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            step(); // E8..E17
            if (i == 5) ur_mode = 1'b1;
            n_checks++;
            if (vsched_count !== 3 || we !== 1'b0 || rd !== 1'b0) begin
                n_fail++;
                $display("FAIL idle[%0d]: got calls=%0d we=%b rd=%b, want 3/0/0", i, vsched_count, we, rd);
            end
        end
        prev_update = update;
        step(); // E18: call 3
        n_checks++;
        if (vsched_count !== 4) begin
            n_fail++;
            $display("FAIL idle_11th: got calls=%0d, want 4", vsched_count);
        end
        $display("idle: 10 ticks, calls=%0d", vsched_count);
    endtask

    task automatic test_delta();
        n_checks++;
        if (update !== ~prev_update) begin
            n_fail++;
            $display("FAIL delta_toggle: got update=%b, want %b", update, ~prev_update);
        end
        for (int i = 0; i < 2; i++) begin
            step(); // E19, E20
            n_checks++;
            if (vsched_count !== 4) begin
                n_fail++;
                $display("FAIL delta_wait[%0d]: got calls=%0d, want 4", i, vsched_count);
            end
        end
        step(); // E21: call 4 -> read 0x40
        n_checks++;
        if (vsched_count !== 5 || rd !== 1'b1 || addr !== 32'h40) begin
            n_fail++;
            $display("FAIL delta_resume: got calls=%0d rd=%b addr=%h, want 5/1/40", vsched_count, rd, addr);
        end
        ur_mode = 1'b0;
        $display("delta: update=%b calls=%0d", update, vsched_count);
    endtask

    task automatic test_reset_mid();
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (rd !== 1'b0 || addr !== 32'h0 || update !== 1'b0 || we !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: got rd=%b addr=%h upd=%b we=%b, want 0/0/0/0", rd, addr, update, we);
        end
        step();
        n_checks++;
        if (vinit_count !== 1) begin
            n_fail++;
            $display("FAIL reset_hold: got vinit=%0d, want 1", vinit_count);
        end
        rst_n = 1'b1;
        step();
        n_checks++;
        if (vinit_count !== 2 || vsched_count !== 5) begin
            n_fail++;
            $display("FAIL reinit: got vinit=%0d calls=%0d, want 2/5", vinit_count, vsched_count);
        end
        $display("reset mid-access: vinit=%0d", vinit_count);
    endtask

    task automatic test_back_to_back();
        step(); // call 5 -> write 0x100
        n_checks++;
        if (we !== 1'b1 || addr !== 32'h100 || dataout !== 32'h1 || vsched_count !== 6) begin
            n_fail++;
            $display("FAIL b2b_first: got we=%b addr=%h data=%h calls=%0d, want 1/100/1/6",
                     we, addr, dataout, vsched_count);
        end
        step(); // call 6 -> rw=3, write wins
        n_checks++;
        if (we !== 1'b1 || rd !== 1'b0 || addr !== 32'h104 || dataout !== 32'h2 || vsched_count !== 7) begin
            n_fail++;
            $display("FAIL b2b_second: got we=%b rd=%b addr=%h data=%h calls=%0d, want 1/0/104/2/7",
                     we, rd, addr, dataout, vsched_count);
        end
        step(); // call 7 -> park
        n_checks++;
        if (we !== 1'b0 || rd !== 1'b0 || vsched_count !== 8) begin
            n_fail++;
            $display("FAIL b2b_end: got we=%b rd=%b calls=%0d, want 0/0/8", we, rd, vsched_count);
        end
        $display("back-to-back: writes 100,104 calls=%0d", vsched_count);
    endtask

    task automatic test_no_delta();
        rst_n = 1'b0;
        rst_n1 = 1'b1;
        step();
        n_checks++;
        if (vinit_count !== 3 || vinit_node !== 4'd9) begin
            n_fail++;
            $display("FAIL nd_init: got vinit=%0d node=%0d, want 3/9", vinit_count, vinit_node);
        end
        step(); // call 8: ticks -1 treated as 0
        n_checks++;
        if (vsched_count !== 9 || update1 !== 1'b0) begin
            n_fail++;
            $display("FAIL nd_first: got calls=%0d update=%b, want 9/0", vsched_count, update1);
        end
        step(); // call 9 on the very next edge
        n_checks++;
        if (vsched_count !== 10 || update1 !== 1'b0) begin
            n_fail++;
            $display("FAIL nd_next: got calls=%0d update=%b, want 10/0", vsched_count, update1);
        end
        $display("no-delta: calls=%0d update=%b", vsched_count, update1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        rst_n1 = 1'b0;
        rdack = 1'b0;
        datain = 32'hFFFF_FFFF;
        interrupt = 3'd5;
        node = 4'd5;
        ur_mode = 1'b0;
        for (int i = 0; i < SCRIPT_LEN; i++) begin
            vproc_pkg::sc_rw[i]    = 2'b00;
            vproc_pkg::sc_addr[i]  = 32'h0;
            vproc_pkg::sc_data[i]  = 32'h0;
            vproc_pkg::sc_ticks[i] = 32'sd1000;
        end
        vproc_pkg::sc_rw[0] = 2'b01; vproc_pkg::sc_addr[0] = 32'h10;  vproc_pkg::sc_data[0] = 32'hDEADBEEF; vproc_pkg::sc_ticks[0] = 0;
        vproc_pkg::sc_rw[1] = 2'b10; vproc_pkg::sc_addr[1] = 32'h0;   vproc_pkg::sc_ticks[1] = 0;
        vproc_pkg::sc_rw[2] = 2'b00; vproc_pkg::sc_ticks[2] = 10;
        vproc_pkg::sc_rw[3] = 2'b00; vproc_pkg::sc_ticks[3] = -1;
        vproc_pkg::sc_rw[4] = 2'b10; vproc_pkg::sc_addr[4] = 32'h40;  vproc_pkg::sc_ticks[4] = 0;
        vproc_pkg::sc_rw[5] = 2'b01; vproc_pkg::sc_addr[5] = 32'h100; vproc_pkg::sc_data[5] = 32'h1; vproc_pkg::sc_ticks[5] = 0;
        vproc_pkg::sc_rw[6] = 2'b11; vproc_pkg::sc_addr[6] = 32'h104; vproc_pkg::sc_data[6] = 32'h2; vproc_pkg::sc_ticks[6] = 0;
        vproc_pkg::sc_rw[8] = 2'b00; vproc_pkg::sc_ticks[8] = -1;

        test_reset();
        test_write();
        test_read();
        test_idle();
        test_delta();
        test_reset_mid();
        test_back_to_back();
        test_no_delta();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vproc.md
Name: vproc

Overview:
- Virtual processor bus master: bridges a host-side C program, reached through DPI-C calls, to a simple 32-bit memory-mapped bus in the simulation.
- Each clock it either completes an outstanding bus access or asks the software side for the next access or idle period.
- Instantiated per node, for example inside simulation-control blocks that expose cycle count, clock period and finish registers.

Parameters:
- DISABLE_DELTA, default 0: 1 means delta-cycle requests (Ticks = -1) are treated as Ticks = 0; 0 means delta handshake via Update/UpdateResponse is enabled.

Ports:
- Clk  in  1  clock; all activity on rising edge.
- nReset  in  1  asynchronous, active-low reset.
- Addr  out  32  access address.
- DataOut  out  32  write data.
- WE  out  1  write request, held until acked.
- WRAck  in  1  write acknowledge.
- DataIn  in  32  read data, sampled on the acking edge.
- RD  out  1  read request, held until acked.
- RDAck  in  1  read acknowledge.
- Interrupt  in  3  interrupt level passed to software (tying to 0 is legal).
- Update  out  1  toggles whenever new outputs are published.
- UpdateResponse  in  1  must equal Update before the next software call.
- Node  in  4  node number passed to every DPI call.

Behaviour:
- Interface: one clock, Clk; reset nReset, asynchronous, active-low.
- DPI imports:
  - VInit(node).
  - VSched(node, irq, datain, out dataout, out addr, out rw, out ticks); rw bit0 = write, bit1 = read; ticks is signed 32-bit.
- Reset (async assert): Addr = 0, DataOut = 0, WE = 0, RD = 0, Update = 0, tick counter = 0, state = INIT.
- INIT: on the first rising edge with nReset high, call VInit(Node) exactly once and go to SCHED. VSched is not called on that edge.
- SCHED, at each rising edge, evaluated in order:
  1. If WE = 1 and WRAck = 0, or RD = 1 and RDAck = 0: hold all outputs; no call.
  2. Else if tick counter > 0: decrement; no call.
  3. Else if Update != UpdateResponse: wait; no call.
  4. Else call VSched(Node, Interrupt, DataIn, ...). DataIn is meaningful only when completing a read; otherwise 0 is passed.
- VSched result:
  - rw bit0 set: WE = 1, RD = 0, Addr and DataOut take the returned values.
  - rw bit1 set (bit0 clear): RD = 1, WE = 0, Addr takes the returned value.
  - rw = 0: WE = 0 and RD = 0.
  - rw = 3: write takes priority.
- Ticks handling after the call:
  - ticks > 0: load the counter, giving that many idle edges after the access completes.
  - ticks = 0: next call occurs on the edge the access is acked, or on the next edge if there is no access.
  - ticks = -1 with DISABLE_DELTA = 0: toggle Update and call again as soon as UpdateResponse matches.
  - ticks = -1 with DISABLE_DELTA = 1: treated as 0.
- Update toggles on every VSched call that changes Addr, DataOut, WE or RD.
- Ack and back-to-back accesses:
  - Ack is a single-edge completion.
  - With WRAck tied to WE, a write lasts exactly one cycle.
  - Back-to-back accesses keep WE/RD high continuously across the completing edge.
- Ack while its request is low: ignored.
- Reset mid-access: outputs clear immediately; the next deassertion re-runs INIT.

Decomposition:
- Package vproc_pkg holds:
  - RW bit positions (VP_WRITE = 0, VP_READ = 1);
  - DELTA_TICKS = -1;
  - DPI import declarations for VInit and VSched.
- No sub-module; a single module with a two-state FSM (INIT, SCHED) and a 32-bit tick counter.

Test Plan (C stub scripted per call):
- Reset then release: VInit is called once with Node = 5; all outputs are 0 during reset; first VSched occurs on the second edge.
- Stub returns write addr 0x10, data 0xDEADBEEF, ticks 0, with WRAck tied to WE: WE is high exactly one cycle, Addr = 0x10, DataOut = 0xDEADBEEF; next call is on the acking edge.
- Stub returns read addr 0x0, DataIn = 0x1234 at ack, with RDAck delayed 3 cycles: RD is held 4 cycles; the next VSched receives datain = 0x1234.
- Stub returns rw = 0, ticks 10: no requests and no VSched calls for 10 edges; call occurs on the 11th.
- DISABLE_DELTA = 0, ticks -1, UpdateResponse delayed 2 cycles: Update toggles; no call until UpdateResponse matches. With DISABLE_DELTA = 1, same stimulus behaves as ticks 0.
- nReset asserted while RD is high: RD drops to 0 asynchronously; after release VInit is called again.
